tc_array: RTL and testbench

- Parametrised successor to the single timer/counter: NUM_CH independent down-counting timers behind one bus slave port.
- Adds per-channel prescaler, one-shot/auto-reload modes, sticky write-1-to-clear pending flags and a per-channel IRQ vector.
- The system bridge decodes the block's address window and drives WE; IRQ[NUM_CH-1:0] feeds the CPU irq inputs.

---
 rtl/tc_array_if.sv | 44 ++++
 rtl/tc_array.sv | 248 ++++++++++++++++++++++++
 tb/tb_tc_array.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_array_if.sv
// -----------------------------------------------------------------------------
// tc_array_if -- register bus between the system bridge and the tc_array timer
// block.
//
// Signals (names follow the bridge side of the system):
//   Addr  [29:0]        word address, bit n here is byte-address bit n+2;
//                       only Addr[4:0] (byte address [6:2]) is decoded
//   WE                  write strobe, one write per cycle
//   Din   [31:0]        write data
//   Dout  [31:0]        combinational read data for Addr
//   IRQ   [NUM_CH-1:0]  per-channel interrupt lines toward the CPU
//
// Handshake: there is no valid/ready pair on this bus. A write is accepted on
// every rising clk edge where WE is high (the slave never stalls), and a read
// is a purely combinational lookup of the currently presented Addr, so Dout is
// valid in the same cycle and has no strobe of its own.
// -----------------------------------------------------------------------------
interface tc_array_if #(
  parameter int NUM_CH = 2
) ();
  logic [29:0]       Addr;
  logic              WE;
  logic [31:0]       Din;
  logic [31:0]       Dout;
  logic [NUM_CH-1:0] IRQ;

  // Bridge / CPU side.
  modport master (
    output Addr,
    output WE,
    output Din,
    input  Dout,
    input  IRQ
  );

  // Timer block side.
  modport slave (
    input  Addr,
    input  WE,
    input  Din,
    output Dout,
    output IRQ
  );
endinterface

// File: rtl/tc_array.sv
// -----------------------------------------------------------------------------
// tc_array -- NUM_CH independent down-counting timers behind one register
// slave port.
//
// Each channel has a prescaler, one-shot / auto-reload modes, a sticky
// write-1-to-clear pending flag and its own interrupt line.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high; clears every register
//   bus          tc_array_if.slave (Addr, WE, Din in; Dout, IRQ out)
//   dbg_state_o  per-channel FSM state, channel i at [2*i+1:2*i]
//
// Register map per channel (ch = byte address [6:4], reg = [3:2]):
//   0 CTRL   bit0 EN, [2:1] MODE (01 auto-reload, else one-shot), bit3 IM,
//            [8+PRESCALE_W-1:8] PSC; other bits read 0
//   1 PRESET [WIDTH-1:0] read/write
//   2 COUNT  [WIDTH-1:0] read-only
//   3 STATUS bit0 PEND, write 1 to clear
// Channels at or above NUM_CH read 0 and ignore writes.
// -----------------------------------------------------------------------------
module tc_array #(
  parameter int NUM_CH     = 2,
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  tc_array_if.slave           bus,
  output logic [2*NUM_CH-1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [2:0] ch_sel;
  logic [1:0] reg_sel;

  assign ch_sel  = bus.Addr[4:2];
  assign reg_sel = bus.Addr[1:0];

  // Upper address bits belong to the bridge's window decode; Din bits outside
  // the register fields are don't-care on writes.
  logic bus_unused;
  assign bus_unused = ^{bus.Addr[29:5], bus.Din};

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  state_e                             state_q [NUM_CH];
  state_e                             state_d [NUM_CH];

  logic [NUM_CH-1:0]                  en_q,     en_d;
  logic [NUM_CH-1:0][1:0]             mode_q,   mode_d;
  logic [NUM_CH-1:0]                  im_q,     im_d;
  logic [NUM_CH-1:0][PRESCALE_W-1:0]  psc_q,    psc_d;
  logic [NUM_CH-1:0][WIDTH-1:0]       preset_q, preset_d;
  logic [NUM_CH-1:0][WIDTH-1:0]       count_q,  count_d;
  logic [NUM_CH-1:0][PRESCALE_W-1:0]  pcnt_q,   pcnt_d;
  logic [NUM_CH-1:0]                  pend_q,   pend_d;

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM action first, then the bus write, then the INT
  // pending set. That ordering gives a CTRL write priority over the one-shot
  // EN clear, and the INT set priority over a same-cycle STATUS clear.
  // ---------------------------------------------------------------------------
  always_comb begin : next_state_logic
    logic wr_hit;
    logic int_set;

    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      en_d[i]     = en_q[i];
      mode_d[i]   = mode_q[i];
      im_d[i]     = im_q[i];
      psc_d[i]    = psc_q[i];
      preset_d[i] = preset_q[i];
      count_d[i]  = count_q[i];
      pcnt_d[i]   = pcnt_q[i];
      pend_d[i]   = pend_q[i];
      int_set     = 1'b0;
      wr_hit      = bus.WE && (ch_sel == 3'(i));

      case (state_q[i])
        ST_IDLE: begin
          if (en_q[i]) begin
            state_d[i] = ST_LOAD;
          end
        end

        ST_LOAD: begin
          count_d[i] = preset_q[i];
          pcnt_d[i]  = '0;
          state_d[i] = en_q[i] ? ST_CNT : ST_IDLE;
        end

        ST_CNT: begin
          if (!en_q[i]) begin
            // Disable freezes COUNT where it is.
            state_d[i] = ST_IDLE;
          end else if (pcnt_q[i] == psc_q[i]) begin
            pcnt_d[i] = '0;
            // "<= 1" also catches a PRESET of 0, which expires on its first
            // tick exactly like a PRESET of 1.
            if (count_q[i] <= WIDTH'(1)) begin
              count_d[i] = '0;
              state_d[i] = ST_INT;
            end else begin
              count_d[i] = count_q[i] - WIDTH'(1);
            end
          end else begin
            pcnt_d[i] = pcnt_q[i] + PRESCALE_W'(1);
          end
        end

        ST_INT: begin
          int_set = 1'b1;
          // MODE is looked at only here, so a mode change mid-count applies
          // to the current expiry.
          if (mode_q[i] == MODE_RELOAD) begin
            state_d[i] = ST_LOAD;
          end else begin
            en_d[i]    = 1'b0;
            state_d[i] = ST_IDLE;
          end
        end

        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase

      if (wr_hit) begin
        case (reg_sel)
          REG_CTRL: begin
            en_d[i]   = bus.Din[0];
            mode_d[i] = bus.Din[2:1];
            im_d[i]   = bus.Din[3];
            psc_d[i]  = bus.Din[8 +: PRESCALE_W];
          end
          REG_PRESET: begin
            // Only copied into COUNT at the next LOAD.
            preset_d[i] = bus.Din[WIDTH-1:0];
          end
          REG_STATUS: begin
            if (bus.Din[0]) begin
              pend_d[i] = 1'b0;
            end
          end
          default: begin
            // COUNT is read-only.
          end
        endcase
      end

      if (int_set) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
      end
      en_q     <= '0;
      mode_q   <= '0;
      im_q     <= '0;
      psc_q    <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pcnt_q   <= '0;
      pend_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
      end
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      psc_q    <= psc_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pcnt_q   <= pcnt_d;
      pend_q   <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux. Looping over implemented channels means an out-of-range channel
  // simply never matches and reads 0.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_data;

  always_comb begin : read_mux
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) begin
        case (reg_sel)
          REG_CTRL: begin
            rd_data[0]                = en_q[i];
            rd_data[2:1]              = mode_q[i];
            rd_data[3]                = im_q[i];
            rd_data[8 +: PRESCALE_W]  = psc_q[i];
          end
          REG_PRESET: rd_data[WIDTH-1:0] = preset_q[i];
          REG_COUNT:  rd_data[WIDTH-1:0] = count_q[i];
          REG_STATUS: rd_data[0]         = pend_q[i];
          default:    rd_data            = '0;
        endcase
      end
    end
  end

  assign bus.Dout = rd_data;

  // PEND stays set while masked; IM only gates the line.
  assign bus.IRQ = pend_q & im_q;

  // ---------------------------------------------------------------------------
  // Debug view of the channel FSMs
  // ---------------------------------------------------------------------------
  always_comb begin : dbg_pack
    dbg_state_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dbg_state_o[2*i +: 2] = state_q[i];
    end
  end

endmodule

// File: tb/tb_tc_array.sv
// -----------------------------------------------------------------------------
// tb_tc_array -- self-checking bench for tc_array.
//
// The reference model tracks each channel as "running since load edge L" and
// derives COUNT and the expiry edge from closed-form timing: with n = preset
// loaded, p = PSC, COUNT at load age a is n - (a-1)/(p+1) (floored at 0) and
// the INT cycle starts at age 1 + max(n,1)*(p+1).
// -----------------------------------------------------------------------------
module tb_tc_array;
  localparam int NUM_CH = 2;
  localparam int WIDTH  = 32;
  localparam int PSC_W  = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  logic [2*NUM_CH-1:0] dbg_state;

  always #5 clk = ~clk;

  tc_array_if #(.NUM_CH(NUM_CH)) bus ();

  tc_array #(
    .NUM_CH    (NUM_CH),
    .WIDTH     (WIDTH),
    .PRESCALE_W(PSC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and expected queue
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          m_en     [NUM_CH];
  int          m_mode   [NUM_CH];
  int          m_im     [NUM_CH];
  int          m_psc    [NUM_CH];
  logic [31:0] m_preset [NUM_CH];
  int          m_pend   [NUM_CH];
  longint      m_count  [NUM_CH];
  longint      m_n      [NUM_CH];
  int          m_L      [NUM_CH];   // load edge, -1 while not running

  function automatic void model_edge(input bit rst, input bit we,
                                     input logic [29:0] addr, input logic [31:0] din);
    for (int c = 0; c < NUM_CH; c++) begin
      bit     set_now;
      int     age;
      longint span;
      longint ticks;
      if (rst) begin
        m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_psc[c] = 0;
        m_preset[c] = '0; m_pend[c] = 0; m_count[c] = 0; m_n[c] = 0; m_L[c] = -1;
        continue;
      end
      set_now = 0;
      if (m_L[c] < 0) begin
        if (m_en[c] != 0) m_L[c] = cyc;
      end else begin
        age  = cyc - m_L[c];
        span = 1 + ((m_n[c] > 1) ? m_n[c] : 1) * longint'(m_psc[c] + 1);
        if (age == 1) begin
          m_n[c]     = longint'(m_preset[c]);
          m_count[c] = m_n[c];
          if (m_en[c] == 0) m_L[c] = -1;
        end else if (age <= span) begin
          if (m_en[c] == 0) begin
            m_L[c] = -1;
          end else begin
            ticks      = longint'(age - 1) / longint'(m_psc[c] + 1);
            m_count[c] = (m_n[c] > ticks) ? (m_n[c] - ticks) : 0;
          end
        end else begin
          set_now   = 1;
          m_pend[c] = 1;
          if (m_mode[c] == 1) begin
            m_L[c] = cyc;
          end else begin
            m_en[c] = 0;
            m_L[c]  = -1;
          end
        end
      end
      if (we && (int'(addr[4:2]) == c)) begin
        case (addr[1:0])
          2'd0: begin
            m_en[c]   = int'(din[0]);
            m_mode[c] = int'(din[2:1]);
            m_im[c]   = int'(din[3]);
            m_psc[c]  = int'(din[8 +: PSC_W]);
          end
          2'd1: m_preset[c] = din;
          2'd3: if (din[0] && !set_now) m_pend[c] = 0;
          default: ;
        endcase
      end
    end
  endfunction

  function automatic logic [31:0] exp_reg(input int ch, input int r);
    logic [31:0] v;
    v = '0;
    if (ch >= NUM_CH) return v;
    case (r)
      0: v = 32'(m_en[ch] | (m_mode[ch] << 1) | (m_im[ch] << 3) | (m_psc[ch] << 8));
      1: v = m_preset[ch];
      2: v = 32'(m_count[ch]);
      default: v = 32'(m_pend[ch]);
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_irq();
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c] = (m_pend[c] != 0) && (m_im[c] != 0);
    return v;
  endfunction

  function automatic logic [29:0] mk_addr(input int ch, input int r);
    return {25'd0, 3'(ch), 2'(r)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    bit          r;
    bit          w;
    logic [29:0] a;
    logic [31:0] d;
    r = reset; w = bus.WE; a = bus.Addr; d = bus.Din;
    @(posedge clk);
    cyc++;
    model_edge(r, w, a, d);
    #1;
    chk("irq", 32'(bus.IRQ), exp_irq());
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    bus.Addr = mk_addr(ch, r);
    bus.Din  = d;
    bus.WE   = 1'b1;
    step();
    bus.WE   = 1'b0;
  endtask

  // Reads settle combinationally; at most 8 per clock cycle fit before the
  // next rising edge.
  task automatic rd(input int ch, input int r, input string tag);
    bus.WE   = 1'b0;
    bus.Addr = mk_addr(ch, r);
    exp_q.push_back(exp_reg(ch, r));
    #1;
    chk(tag, bus.Dout, exp_q.pop_front());
  endtask

  task automatic rd_lit(input int ch, input int r, input logic [31:0] v, input string tag);
    bus.WE   = 1'b0;
    bus.Addr = mk_addr(ch, r);
    #1;
    chk(tag, bus.Dout, v);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int op;
    int c;
    int rc;
    logic [31:0] d;

    reset    = 1'b1;
    bus.WE   = 1'b0;
    bus.Addr = '0;
    bus.Din  = '0;
    step();
    step();
    reset = 1'b0;

    // Reset values
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int r = 0; r < 4; r++) rd_lit(ch, r, 32'd0, "rst_reg");
    chk("rst_irq", 32'(bus.IRQ), 32'd0);
    chk("rst_dbg", 32'(dbg_state), 32'd0);
    step();
    rd_lit(5, 0, 32'd0, "ch5_rd");
    wr(5, 0, 32'hFFFF_FFFF);
    wr(5, 1, 32'h1234_5678);
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int r = 0; r < 4; r++) rd_lit(ch, r, 32'd0, "ch5_wr_ignored");

    // One-shot ch0, PRESET=3, EN|IM
    wr(0, 1, 32'd3);
    wr(0, 0, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      step();
      rd(0, 2, "os_count");
      if (k >= 2 && k <= 5) chk("os_count_lit", bus.Dout, 32'(5 - k));
      if (k == 5) chk("os_irq_e5", 32'(bus.IRQ[0]), 32'd0);
      if (k == 6) chk("os_irq_e6", 32'(bus.IRQ[0]), 32'd1);
    end
    rd_lit(0, 0, 32'h8, "os_ctrl_en_cleared");
    step();
    step();
    chk("os_irq_hold", 32'(bus.IRQ[0]), 32'd1);
    wr(0, 3, 32'd1);
    chk("os_irq_clr", 32'(bus.IRQ[0]), 32'd0);

    // Auto-reload ch1, PRESET=2, period 4, W1C after each expiry
    wr(1, 1, 32'd2);
    wr(1, 0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      if (k == 6 || k == 10 || k == 14) wr(1, 3, 32'd1);
      else step();
      rd(1, 2, "ar_count");
      rd(0, 2, "ar_ch0_count");
      rd(0, 0, "ar_ch0_ctrl");
      if (k == 4 || k == 8 || k == 12) chk("ar_irq_low", 32'(bus.IRQ[1]), 32'd0);
      if (k == 5 || k == 9 || k == 13) chk("ar_irq_high", 32'(bus.IRQ[1]), 32'd1);
    end
    wr(1, 0, 32'd0);
    wr(1, 3, 32'd1);

    // Prescaler ch0: PRESET=2, PSC=3, then disable mid-count
    wr(0, 1, 32'd2);
    wr(0, 0, 32'h0000_0309);
    for (int k = 1; k <= 7; k++) begin
      step();
      rd(0, 2, "psc_count");
      if (k >= 2) chk("psc_count_lit", bus.Dout, 32'(2 - (k - 2) / 4));
    end
    wr(0, 0, 32'h0000_0308);
    for (int k = 0; k < 8; k++) begin
      step();
      rd_lit(0, 2, 32'd1, "psc_frozen");
      rd(0, 3, "psc_no_pend");
      chk("psc_no_irq", 32'(bus.IRQ[0]), 32'd0);
    end

    // W1C in the INT cycle: set wins
    wr(0, 1, 32'd1);
    wr(0, 0, 32'h9);
    step(); step(); step();
    wr(0, 3, 32'd1);
    rd_lit(0, 3, 32'd1, "w1c_int_collide");
    wr(0, 3, 32'd1);
    rd_lit(0, 3, 32'd0, "w1c_clear");

    // PRESET rewritten mid-count: current period runs from 10, reload uses 5
    wr(0, 1, 32'd10);
    wr(0, 0, 32'hB);
    step(); step(); step(); step();
    wr(0, 1, 32'd5);
    for (int e = 6; e <= 22; e++) begin
      step();
      rd(0, 2, "prl_count");
      if (e == 12) chk("prl_irq_e12", 32'(bus.IRQ[0]), 32'd0);
      if (e == 13) chk("prl_irq_e13", 32'(bus.IRQ[0]), 32'd1);
      if (e == 14) chk("prl_reload5", bus.Dout, 32'd5);
    end
    wr(0, 0, 32'd0);
    wr(0, 3, 32'd1);

    // Masking: PEND without IRQ, then unmask
    wr(1, 1, 32'd1);
    wr(1, 0, 32'h1);
    for (int k = 0; k < 5; k++) step();
    rd_lit(1, 3, 32'd1, "mask_pend");
    chk("mask_irq_low", 32'(bus.IRQ[1]), 32'd0);
    wr(1, 0, 32'h8);
    chk("unmask_irq", 32'(bus.IRQ[1]), 32'd1);
    wr(1, 3, 32'd1);

    // Randomised traffic
    for (int k = 0; k < 2500; k++) begin
      op = $urandom_range(0, 99);
      c  = $urandom_range(0, NUM_CH - 1);
      if (op < 40) begin
        for (int j = 0; j < 2; j++) begin
          rc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NUM_CH - 1);
          rd(rc, $urandom_range(0, 3), "rnd_rd");
        end
        step();
      end else if (op < 52) begin
        wr(c, 3, 32'($urandom_range(0, 1)));
      end else if (op < 62) begin
        wr(c, 1, 32'($urandom_range(0, 7)));
      end else if (op < 74) begin
        d = $urandom & 32'hFF00_00F0;
        d[0] = ($urandom_range(0, 9) < 8);
        d[2:1] = 2'($urandom_range(0, 3));
        d[3] = 1'($urandom_range(0, 1));
        if (m_L[c] >= 0 || m_en[c] != 0) d[8 +: PSC_W] = PSC_W'(m_psc[c]);
        else d[8 +: PSC_W] = PSC_W'($urandom_range(0, 3));
        wr(c, 0, d);
      end else if (op < 78) begin
        if ($urandom_range(0, 1) == 0) wr($urandom_range(NUM_CH, 7), $urandom_range(0, 3), $urandom);
        else wr(c, 2, $urandom);
      end else begin
        step();
      end
    end

    // Reset in the middle of a count
    wr(0, 1, 32'd7);
    wr(0, 0, 32'hB);
    wr(1, 1, 32'd3);
    wr(1, 0, 32'hB);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int r = 0; r < 4; r++) rd_lit(ch, r, 32'd0, "midrst_reg");
    chk("midrst_irq", 32'(bus.IRQ), 32'd0);
    chk("midrst_dbg", 32'(dbg_state), 32'd0);
    for (int k = 0; k < 12; k++) step();
    chk("midrst_quiet", 32'(bus.IRQ), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
